adc_reader: RTL and testbench
=============================

ADC_READER -- requirements
Module: adc_reader

Interface
REQ-001 SHALL have parameter WR_CYC, default 50, meaning cycles adc_wrn is held low per conversion start.
REQ-002 SHALL have parameter RD_CYC, default 30, meaning cycles adc_rdn is held low per read.
REQ-003 SHALL have parameter GAP_CYC, default 200, meaning idle cycles after each read or timeout.
REQ-004 SHALL have parameter TMO_CYC, default 1000, meaning maximum cycles to wait for end-of-conversion.
REQ-005 SHALL have port clk, input, 1, system clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, single-conversion request, one-cycle pulse.
REQ-008 SHALL have port auto_en, input, 1, free-running conversions while high.
REQ-009 SHALL have port adc_intrn, input, 1, asynchronous ADC end-of-conversion, active low.
REQ-010 SHALL have port adc_d, input, 8, ADC parallel data bus.
REQ-011 SHALL have port adc_csn, output, 1, ADC chip select, active low.
REQ-012 SHALL have port adc_wrn, output, 1, conversion-start strobe, active low.
REQ-013 SHALL have port adc_rdn, output, 1, read strobe, active low.
REQ-014 SHALL have port sample, output, 8, last published sample.
REQ-015 SHALL have port sample_valid, output, 1, one-cycle pulse when sample updates.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have port timeout, output, 1, one-cycle pulse on end-of-conversion timeout.

Function
REQ-018 SHALL implement states IDLE, CONV, WAIT, READ, GAP, all registered; all outputs driven from registers.
REQ-019 IDLE SHALL go to CONV on the cycle after start=1 or auto_en=1; a start arriving in any other state SHALL be ignored.
REQ-020 CONV SHALL drive adc_csn=0 and adc_wrn=0 for exactly WR_CYC cycles, then enter WAIT with adc_wrn=1.
REQ-021 adc_intrn SHALL pass through a 2-flop synchronizer; WAIT SHALL leave for READ on the first cycle the synchronized value is 0.
REQ-022 WAIT SHALL enter GAP and pulse timeout for one cycle if intrn is not seen within TMO_CYC cycles; sample and sample_valid SHALL be unchanged.
REQ-023 READ SHALL drive adc_csn=0 and adc_rdn=0 for exactly RD_CYC cycles, capturing adc_d on the last low cycle; adc_rdn SHALL return to 1 on the following cycle.
REQ-024 GAP SHALL hold all strobes high for GAP_CYC cycles, then return to IDLE.
REQ-025 adc_csn SHALL be 1 in IDLE and GAP and 0 in CONV, WAIT and READ.
REQ-026 The cycle counter SHALL be 16 bits, clear on every state change and never wrap within a state.
REQ-027 If adc_intrn is already low on WAIT entry, the transition to READ SHALL occur after the synchronizer latency of 2 cycles.

Reset
REQ-028 While rst=0: state=IDLE, counter=0, adc_csn=1, adc_wrn=1, adc_rdn=1, sample=8'h00, sample_valid=0, timeout=0, busy=0, synchronizer flops=1.
REQ-029 Reset asserted mid-transaction SHALL abort it immediately, with no sample_valid or timeout pulse on release.

Configuration
REQ-030 Macro ADC_AVG_EN: when defined, captures SHALL accumulate into a 10-bit sum; every 4th capture sample=sum[9:2], sample_valid pulses, and the sum clears; timeouts and reset SHALL clear the partial sum and count.
REQ-031 Without ADC_AVG_EN, every capture SHALL set sample=adc_d and pulse sample_valid one cycle after the capture.

Verification
REQ-032 Single start with adc_d=8'hA5, intrn low 10 cycles after wrn rises -> wrn low 50 cycles, rdn low 30 cycles, sample=8'hA5, one sample_valid pulse.
REQ-033 adc_intrn held high -> timeout pulse exactly TMO_CYC cycles after WAIT entry, sample unchanged, return to IDLE after GAP_CYC cycles.
REQ-034 auto_en=1 with fixed response timing -> back-to-back conversions with a constant period; a start pulse during busy causes no extra conversion.
REQ-035 rst driven low during READ -> all strobes at 1 and sample=8'h00 asynchronously; no sample_valid after release.
REQ-036 With ADC_AVG_EN, captures 10, 20, 30, 41 -> single sample_valid with sample=25; no pulse on captures 1-3.

Source files
------------

// File: rtl/adc_reader.sv
// adc_reader: sequences an 8-bit parallel ADC through a write strobe, a wait for
// end-of-conversion, a read strobe and an idle gap. All outputs are registered.
// Optional feature: define ADC_AVG_EN to average every 4 captures before publishing.
`timescale 1ns / 1ps

module adc_reader #(
  parameter int unsigned WR_CYC  = 50,
  parameter int unsigned RD_CYC  = 30,
  parameter int unsigned GAP_CYC = 200,
  parameter int unsigned TMO_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       auto_en,
  input  logic       adc_intrn,
  input  logic [7:0] adc_d,
  output logic       adc_csn,
  output logic       adc_wrn,
  output logic       adc_rdn,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [2:0] {StIdle, StConv, StWait, StRead, StGap} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  logic        intrn_s1_q;
  logic        intrn_s2_q;

  // Counter saturates so it can never wrap within a long-lived state.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

`ifdef ADC_AVG_EN
  logic [9:0] sum_q;
  logic [1:0] acc_cnt_q;
  logic [9:0] sum_nxt;

  assign sum_nxt = sum_q + {2'b00, adc_d};
`endif

  // Two-flop synchronizer for the asynchronous end-of-conversion input; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intrn_s1_q <= 1'b1;
      intrn_s2_q <= 1'b1;
    end else begin
      intrn_s1_q <= adc_intrn;
      intrn_s2_q <= intrn_s1_q;
    end
  end

  // Main sequencer: state, cycle counter, strobes and published sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      adc_csn      <= 1'b1;
      adc_wrn      <= 1'b1;
      adc_rdn      <= 1'b1;
      sample       <= 8'h00;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      timeout      <= 1'b0;
`ifdef ADC_AVG_EN
      sum_q        <= 10'd0;
      acc_cnt_q    <= 2'd0;
`endif
    end else begin
      sample_valid <= 1'b0;
      timeout      <= 1'b0;
      cnt_q        <= cnt_inc;
      case (state_q)
        StIdle: begin
          cnt_q <= 16'd0;
          if (start || auto_en) begin
            state_q <= StConv;
            adc_csn <= 1'b0;
            adc_wrn <= 1'b0;
            busy    <= 1'b1;
          end
        end
        StConv: begin
          if (cnt_q == 16'(WR_CYC - 1)) begin
            state_q <= StWait;
            adc_wrn <= 1'b1;
            cnt_q   <= 16'd0;
          end
        end
        StWait: begin
          // A seen end-of-conversion wins over a coincident timeout.
          if (!intrn_s2_q) begin
            state_q <= StRead;
            adc_rdn <= 1'b0;
            cnt_q   <= 16'd0;
          end else if (cnt_q == 16'(TMO_CYC - 1)) begin
            state_q <= StGap;
            adc_csn <= 1'b1;
            timeout <= 1'b1;
            cnt_q   <= 16'd0;
`ifdef ADC_AVG_EN
            sum_q     <= 10'd0;
            acc_cnt_q <= 2'd0;
`endif
          end
        end
        StRead: begin
          // Capture on the last low cycle of the read strobe.
          if (cnt_q == 16'(RD_CYC - 1)) begin
            state_q <= StGap;
            adc_rdn <= 1'b1;
            adc_csn <= 1'b1;
            cnt_q   <= 16'd0;
`ifdef ADC_AVG_EN
            if (acc_cnt_q == 2'd3) begin
              sample       <= sum_nxt[9:2];
              sample_valid <= 1'b1;
              sum_q        <= 10'd0;
              acc_cnt_q    <= 2'd0;
            end else begin
              sum_q     <= sum_nxt;
              acc_cnt_q <= acc_cnt_q + 2'd1;
            end
`else
            sample       <= adc_d;
            sample_valid <= 1'b1;
`endif
          end
        end
        StGap: begin
          if (cnt_q == 16'(GAP_CYC - 1)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            cnt_q   <= 16'd0;
          end
        end
        default: begin
          state_q <= StIdle;
          adc_csn <= 1'b1;
          adc_wrn <= 1'b1;
          adc_rdn <= 1'b1;
          busy    <= 1'b0;
          cnt_q   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_reader.sv
// Self-checking bench for adc_reader: table of single transactions plus hand-written
// sequences for start-while-busy, free-running period and reset during a read.
`timescale 1ns / 1ps

module tb_adc_reader;

  localparam int WR  = 50;
  localparam int RD  = 30;
  localparam int GAP = 200;
  localparam int TMO = 1000;
  localparam int SWRN = 0, SRDN = 1, SBUSY = 2, STMO = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       auto_en = 1'b0;
  logic       adc_intrn = 1'b1;
  logic [7:0] adc_d = 8'h00;
  logic       adc_csn, adc_wrn, adc_rdn, sample_valid, busy, timeout;
  logic [7:0] sample;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int tmo_cnt = 0;
  int falls = 0;
  logic wrn_prev = 1'b1;

  adc_reader #(.WR_CYC(WR), .RD_CYC(RD), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .adc_intrn(adc_intrn),
    .adc_d(adc_d), .adc_csn(adc_csn), .adc_wrn(adc_wrn), .adc_rdn(adc_rdn),
    .sample(sample), .sample_valid(sample_valid), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the rising edge (pre-update values).
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    wrn_prev <= adc_wrn;
    if (sample_valid) valid_cnt <= valid_cnt + 1;
    if (timeout) tmo_cnt <= tmo_cnt + 1;
    if (wrn_prev && !adc_wrn) falls <= falls + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] d;
    int         dly;
    bit         tmo;
    bit         exp_valid;
    logic [7:0] exp_sample;
  } vec_t;

  vec_t vecs[6];
  int   nvec;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      SWRN:    sig = adc_wrn;
      SRDN:    sig = adc_rdn;
      SBUSY:   sig = busy;
      STMO:    sig = timeout;
      default: sig = adc_csn;
    endcase
  endfunction

  // Step negedges until the selected output reaches lvl; n = steps taken.
  task automatic wait_sig(input int w, input logic lvl, input int limit, output int n);
    n = 0;
    while (sig(w) !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sig(w) !== lvl) begin
      total++;
      bad++;
      $display("FAIL wait_sig%0d: level %0d not reached in %0d cycles", w, lvl, limit);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int v0, t0;
    logic [7:0] s0;
    v0 = valid_cnt;
    t0 = tmo_cnt;
    s0 = sample;
    adc_d = v.d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("conv_entry_wrn", int'(adc_wrn), 0);
    chk("conv_csn", int'(adc_csn), 0);
    wait_sig(SWRN, 1'b1, 2000, n);
    chk("wr_low_cycles", n, WR);
    chk("wait_csn", int'(adc_csn), 0);
    if (v.tmo) begin
      wait_sig(STMO, 1'b1, 2000, n);
      chk("timeout_latency", n, TMO);
      chk("tmo_csn", int'(adc_csn), 1);
    end else begin
      repeat (v.dly) @(negedge clk);
      adc_intrn = 1'b0;
      wait_sig(SRDN, 1'b0, 50, n);
      chk("sync_latency", n, 3);
      wait_sig(SRDN, 1'b1, 2000, n);
      chk("rd_low_cycles", n, RD);
      chk("valid_at_rdn_rise", int'(sample_valid), int'(v.exp_valid));
      chk("read_done_csn", int'(adc_csn), 1);
      adc_intrn = 1'b1;
    end
    wait_sig(SBUSY, 1'b0, 2000, n);
    chk("gap_cycles", n, GAP);
    chk("sample", int'(sample), int'(v.tmo ? s0 : v.exp_sample));
    chk("valid_pulses", valid_cnt - v0, int'(v.exp_valid));
    chk("timeout_pulses", tmo_cnt - t0, int'(v.tmo));
  endtask

  // Answer one conversion with a fixed end-of-conversion delay.
  task automatic serve(input int dly, output int fall_cyc);
    int n;
    wait_sig(SWRN, 1'b0, 400, n);
    fall_cyc = cyc;
    wait_sig(SWRN, 1'b1, 2000, n);
    repeat (dly) @(negedge clk);
    adc_intrn = 1'b0;
    wait_sig(SRDN, 1'b0, 50, n);
    wait_sig(SRDN, 1'b1, 2000, n);
    adc_intrn = 1'b1;
  endtask

  initial begin
    int n, f0, f1, f2, f3, v0, t0;
`ifdef ADC_AVG_EN
    vecs[0] = '{d: 8'd10, dly: 3, tmo: 1'b0, exp_valid: 1'b0, exp_sample: 8'h00};
    vecs[1] = '{d: 8'd20, dly: 0, tmo: 1'b0, exp_valid: 1'b0, exp_sample: 8'h00};
    vecs[2] = '{d: 8'd30, dly: 6, tmo: 1'b0, exp_valid: 1'b0, exp_sample: 8'h00};
    vecs[3] = '{d: 8'd41, dly: 1, tmo: 1'b0, exp_valid: 1'b1, exp_sample: 8'd25};
    nvec = 4;
`else
    vecs[0] = '{d: 8'hA5, dly: 10, tmo: 1'b0, exp_valid: 1'b1, exp_sample: 8'hA5};
    vecs[1] = '{d: 8'h3C, dly: 0,  tmo: 1'b0, exp_valid: 1'b1, exp_sample: 8'h3C};
    vecs[2] = '{d: 8'hFF, dly: 7,  tmo: 1'b0, exp_valid: 1'b1, exp_sample: 8'hFF};
    vecs[3] = '{d: 8'h5A, dly: 0,  tmo: 1'b1, exp_valid: 1'b0, exp_sample: 8'hFF};
    vecs[4] = '{d: 8'h00, dly: 2,  tmo: 1'b0, exp_valid: 1'b1, exp_sample: 8'h00};
    vecs[5] = '{d: 8'h81, dly: 25, tmo: 1'b0, exp_valid: 1'b1, exp_sample: 8'h81};
    nvec = 6;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_csn", int'(adc_csn), 1);
    chk("rst_wrn", int'(adc_wrn), 1);
    chk("rst_rdn", int'(adc_rdn), 1);
    chk("rst_sample", int'(sample), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < nvec; i++) run_txn(vecs[i]);

    // Start pulses during CONV and GAP must not add a conversion.
    f0 = falls;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sig(SWRN, 1'b1, 2000, n);
    repeat (4) @(negedge clk);
    adc_intrn = 1'b0;
    wait_sig(SRDN, 1'b0, 50, n);
    wait_sig(SRDN, 1'b1, 2000, n);
    adc_intrn = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sig(SBUSY, 1'b0, 2000, n);
    repeat (300) @(negedge clk);
    chk("start_while_busy_convs", falls - f0, 1);
    chk("start_while_busy_idle", int'(busy), 0);

    // Free-running: constant period of 1 + WR + (dly + 3) + RD + GAP.
    f0 = falls;
    auto_en = 1'b1;
    serve(5, f1);
    serve(5, f2);
    serve(5, f3);
    auto_en = 1'b0;
    wait_sig(SBUSY, 1'b0, 2000, n);
    repeat (50) @(negedge clk);
    chk("auto_period_1", f2 - f1, 1 + WR + 8 + RD + GAP);
    chk("auto_period_2", f3 - f2, 1 + WR + 8 + RD + GAP);
    chk("auto_conv_count", falls - f0, 3);

    // Reset asserted during READ aborts asynchronously.
    v0 = valid_cnt;
    t0 = tmo_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sig(SWRN, 1'b1, 2000, n);
    adc_intrn = 1'b0;
    wait_sig(SRDN, 1'b0, 50, n);
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_csn", int'(adc_csn), 1);
    chk("midrst_wrn", int'(adc_wrn), 1);
    chk("midrst_rdn", int'(adc_rdn), 1);
    chk("midrst_sample", int'(sample), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    adc_intrn = 1'b1;
    repeat (300) @(negedge clk);
    chk("midrst_no_valid", valid_cnt - v0, 0);
    chk("midrst_no_timeout", tmo_cnt - t0, 0);
    chk("midrst_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
